// File: rtl/alarm_sequencer.sv
// Egg-timer alarm: beep bursts after the countdown ends, stopped by ack/disable/limit.
// Define ALARM_FLASH_EN to blank the display in step with the buzzer.
module alarm_sequencer #(
    parameter int BEEP_TICKS      = 10,
    parameter int GAP_TICKS       = 10,
    parameter int BEEPS_PER_BURST = 3,
    parameter int BURST_GAP_TICKS = 50,
    parameter int MAX_BURSTS      = 30,
    parameter int CTR_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 timer_done,
    input  logic                 timer_en,
    input  logic                 ack,
    output logic                 buzzer,
    output logic                 display_blank,
    output logic                 alarm_active,
    output logic                 expired,
    output logic [CTR_WIDTH-1:0] burst_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] BEEP_ON   = 3'd1;
    localparam logic [2:0] BEEP_OFF  = 3'd2;
    localparam logic [2:0] BURST_GAP = 3'd3;
    localparam logic [2:0] HOLDOFF   = 3'd4;

    localparam logic [CTR_WIDTH-1:0] ON_LIM  = CTR_WIDTH'(BEEP_TICKS - 1);
    localparam logic [CTR_WIDTH-1:0] OFF_LIM = CTR_WIDTH'(GAP_TICKS - 1);
    localparam logic [CTR_WIDTH-1:0] BG_LIM  = CTR_WIDTH'(BURST_GAP_TICKS - 1);
    localparam logic [CTR_WIDTH-1:0] LAST_BEEP = CTR_WIDTH'(BEEPS_PER_BURST - 1);
    localparam logic [CTR_WIDTH-1:0] MAX_B   = CTR_WIDTH'(MAX_BURSTS);

    logic [2:0]           state;
    logic [2:0]           nxt;
    logic [CTR_WIDTH-1:0] phase;
    logic [CTR_WIDTH-1:0] beep_ctr;
    logic [CTR_WIDTH-1:0] limit;
    logic                 done_q;
    logic                 phase_end;
    logic                 start;
    logic                 burst_end;
    logic                 next_beep;
    logic                 next_burst;
    logic                 expire;
    logic                 live;

    always_comb begin
        limit = '0;
        case (state)
            BEEP_ON:   limit = ON_LIM;
            BEEP_OFF:  limit = OFF_LIM;
            BURST_GAP: limit = BG_LIM;
            default:   limit = '0;
        endcase
    end

    // Tick-driven moves only apply when neither disable nor ack is asserted
    assign live       = timer_en && !ack;
    assign phase_end  = live && tick && (phase == limit);
    assign start      = (state == IDLE) && timer_done && !done_q && live;
    assign burst_end  = (state == BEEP_ON) && phase_end && (beep_ctr >= LAST_BEEP);
    assign next_beep  = (state == BEEP_OFF) && phase_end;
    assign next_burst = (state == BURST_GAP) && phase_end && (burst_count != MAX_B);
    assign expire     = (state == BURST_GAP) && phase_end && (burst_count == MAX_B);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (start) nxt = BEEP_ON;
            end
            BEEP_ON: begin
                if (!timer_en)      nxt = IDLE;
                else if (ack)       nxt = HOLDOFF;
                else if (burst_end) nxt = BURST_GAP;
                else if (phase_end) nxt = BEEP_OFF;
            end
            BEEP_OFF: begin
                if (!timer_en)      nxt = IDLE;
                else if (ack)       nxt = HOLDOFF;
                else if (next_beep) nxt = BEEP_ON;
            end
            BURST_GAP: begin
                if (!timer_en)       nxt = IDLE;
                else if (ack)        nxt = HOLDOFF;
                else if (expire)     nxt = HOLDOFF;
                else if (next_burst) nxt = BEEP_ON;
            end
            HOLDOFF: begin
                if (!timer_en || !timer_done) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            phase        <= '0;
            beep_ctr     <= '0;
            burst_count  <= '0;
            expired      <= 1'b0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= timer_done;

            if (nxt != state || state == IDLE || state == HOLDOFF)
                phase <= '0;
            else if (tick)
                phase <= phase + 1'b1;

            if (start || next_burst)
                beep_ctr <= '0;
            else if (next_beep)
                beep_ctr <= beep_ctr + 1'b1;

            if (start)
                burst_count <= '0;
            else if (burst_end && burst_count != MAX_B)
                burst_count <= burst_count + 1'b1;

            if (start || !timer_en)
                expired <= 1'b0;
            else if (expire)
                expired <= 1'b1;

            buzzer       <= (nxt == BEEP_ON);
            alarm_active <= (nxt == BEEP_ON) || (nxt == BEEP_OFF) ||
                            (nxt == BURST_GAP);
        end
    end

`ifdef ALARM_FLASH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            display_blank <= 1'b0;
        else
            display_blank <= (nxt == BEEP_ON);
    end
`else
    assign display_blank = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus random stimulus
// against a tick-position model of the beep pattern.
module tb_alarm_sequencer;

    localparam int BEEP = 2;
    localparam int GAP  = 1;
    localparam int BPB  = 3;
    localparam int BGAP = 4;
    localparam int MAXB = 2;
    localparam int SPAN = BPB * BEEP + (BPB - 1) * GAP;
    localparam int L    = SPAN + BGAP;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       timer_done = 1'b0;
    logic       timer_en = 1'b0;
    logic       ack = 1'b0;
    logic       buzzer;
    logic       display_blank;
    logic       alarm_active;
    logic       expired;
    logic [7:0] burst_count;

    int tests = 0;
    int fails = 0;

    int   m_mode = M_IDLE;
    int   m_n    = 0;
    int   m_bc   = 0;
    logic m_exp  = 1'b0;
    logic m_dq   = 1'b0;

    logic [0:11] pat = 12'b110110110000;

    alarm_sequencer #(
        .BEEP_TICKS(BEEP), .GAP_TICKS(GAP), .BEEPS_PER_BURST(BPB),
        .BURST_GAP_TICKS(BGAP), .MAX_BURSTS(MAXB), .CTR_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .timer_done(timer_done),
        .timer_en(timer_en), .ack(ack), .buzzer(buzzer),
        .display_blank(display_blank), .alarm_active(alarm_active),
        .expired(expired), .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    function automatic logic buz_of(int n);
        int pos;
        pos = n % L;
        return (pos < SPAN) && ((pos % (BEEP + GAP)) < BEEP);
    endfunction

    function automatic int bc_of(int n);
        int b;
        b = n / L + (((n % L) >= SPAN) ? 1 : 0);
        return (b > MAXB) ? MAXB : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic eb;
        eb = (m_mode == M_RUN) && buz_of(m_n);
        chk("buzzer", {31'd0, buzzer}, {31'd0, eb});
        chk("alarm_active", {31'd0, alarm_active},
            {31'd0, m_mode == M_RUN});
        chk("expired", {31'd0, expired}, {31'd0, m_exp});
        chk("burst_count", {24'd0, burst_count}, m_bc);
`ifdef ALARM_FLASH_EN
        chk("display_blank", {31'd0, display_blank}, {31'd0, eb});
`else
        chk("display_blank", {31'd0, display_blank}, 32'd0);
`endif
    endtask

    task automatic step(input logic t, input logic d,
                        input logic e, input logic a);
        tick = t; timer_done = d; timer_en = e; ack = a;
        case (m_mode)
            M_IDLE: begin
                if (d && !m_dq && e && !a) begin
                    m_mode = M_RUN; m_n = 0; m_exp = 1'b0; m_bc = 0;
                end else if (!e) begin
                    m_exp = 1'b0;
                end
            end
            M_RUN: begin
                if (!e) begin
                    m_mode = M_IDLE; m_exp = 1'b0;
                end else if (a) begin
                    m_mode = M_HOLD;
                end else if (t) begin
                    m_n++;
                    if (m_n == MAXB * L) begin
                        m_mode = M_HOLD; m_exp = 1'b1;
                    end
                end
            end
            default: begin
                if (!e) begin
                    m_mode = M_IDLE; m_exp = 1'b0;
                end else if (!d) begin
                    m_mode = M_IDLE;
                end
            end
        endcase
        if (m_mode == M_RUN) m_bc = bc_of(m_n);
        m_dq = d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_n = 0; m_bc = 0; m_exp = 1'b0; m_dq = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // single burst timing and expiry
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        chk("pattern", {31'd0, buzzer}, {31'd0, pat[0]});
        for (int i = 1; i < 12; i++) begin
            step(1, 1, 1, 0);
            chk("pattern", {31'd0, buzzer}, {31'd0, pat[i]});
        end
        for (int i = 0; i < 16; i++) step(1, 1, 1, 0);
        chk("expired_hold", {31'd0, expired}, 32'd1);
        chk("bc_hold", {24'd0, burst_count}, 32'd2);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);

        // ack during second beep, then no retrigger while done stays high
        step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        chk("ack_buzzer", {31'd0, buzzer}, 32'd0);
        for (int i = 0; i < 50; i++) step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        chk("retrigger", {31'd0, buzzer}, 32'd1);

        // disable beats ack in BEEP_OFF
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 1);
        step(0, 0, 1, 0);

        // done edge while disabled, then ack on the done edge
        step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        step(1, 1, 1, 0);
        chk("ack_suppress", {31'd0, alarm_active}, 32'd0);

        // randomized soak
        for (int i = 0; i < 600; i++) begin
            logic t, d, e, a;
            t = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 29) == 0) ? !timer_done : timer_done;
            e = ($urandom_range(0, 59) != 0);
            a = ($urandom_range(0, 39) == 0);
            step(t, d, e, a);
        end

        // async reset in the middle of a beep
        step(0, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
        chk("post_reset_idle", {31'd0, alarm_active}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Drives the egg timer's buzzer and, optionally, the display blank once the countdown finishes.
- Starts on the rising edge of the main timer's done flag and emits bursts of beeps. Each burst is a fixed number of beeps, and a longer gap separates bursts.
- Stops on user acknowledge, when the timer is disabled, or after a burst limit.
- Sits between the main controller/time counter and the board outputs. It is clocked by the 1 kHz system clock and paced by the 10 ms clock-enable pulse.

Parameters:
- BEEP_TICKS, 10, ticks the buzzer is on per beep (100 ms at a 10 ms tick)
- GAP_TICKS, 10, silent ticks between beeps inside a burst
- BEEPS_PER_BURST, 3, beeps per burst (>=1)
- BURST_GAP_TICKS, 50, silent ticks between bursts
- MAX_BURSTS, 30, bursts before the alarm gives up (>=1)
- CTR_WIDTH, 8, width of the tick/beep/burst counters; must hold every parameter value

Ports:
- clk  in  1  system clock (1 kHz)
- reset  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle clock enable (10 ms pulse); all timing counts only on tick
- timer_done  in  1  level from main time counter, high while count is 00:00
- timer_en  in  1  timer enable switch
- ack  in  1  debounced acknowledge button, level
- buzzer  out  1  registered buzzer drive
- display_blank  out  1  registered display blank request (see Optional Feature)
- alarm_active  out  1  high while a beep pattern is running
- expired  out  1  sticky: alarm ran MAX_BURSTS without ack
- burst_count  out  CTR_WIDTH  bursts completed in the current alarm

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - buzzer, display_blank, alarm_active, expired = 0; burst_count = 0.
  - done_q = 0, where done_q is timer_done registered each clk.
- States: IDLE, BEEP_ON, BEEP_OFF, BURST_GAP, HOLDOFF.
- Outputs are registered decodes of the next state:
  - buzzer=1 only in BEEP_ON.
  - alarm_active=1 in BEEP_ON/BEEP_OFF/BURST_GAP.
- Trigger: in IDLE, when timer_done=1, done_q=0, timer_en=1 and ack=0:
  - next edge -> BEEP_ON.
  - buzzer and alarm_active rise on that same edge, i.e. 1-cycle latency from the done edge.
  - Phase counter, beep counter and burst_count are cleared; expired is cleared.
- A level-high timer_done in IDLE with no rising edge never triggers.
- Phase counter:
  - Cleared on every state entry; increments on tick.
  - A state exits on the tick on which the counter equals its limit-1.
  - Each phase therefore lasts exactly its limit in ticks.
- BEEP_ON (BEEP_TICKS):
  - If beeps completed < BEEPS_PER_BURST-1 -> BEEP_OFF.
  - Otherwise -> BURST_GAP, and burst_count increments.
- BEEP_OFF (GAP_TICKS) -> BEEP_ON; beep counter increments.
- BURST_GAP (BURST_GAP_TICKS):
  - If burst_count == MAX_BURSTS -> HOLDOFF with expired=1.
  - Otherwise -> BEEP_ON with the beep counter cleared.
- Ack: ack=1 in any alarm state -> HOLDOFF next edge, buzzer low the same edge.
  - Ack takes priority over any tick-driven transition in the same cycle.
  - Ack in the trigger cycle suppresses the alarm: stay in IDLE.
- Disable: timer_en=0 in any alarm state or HOLDOFF -> IDLE next edge and clears expired. Disable has priority over ack.
- HOLDOFF:
  - Stays until timer_done=0, then -> IDLE. This prevents retrigger while the count stays at 00:00.
  - expired holds until the next trigger, timer_en=0 or reset.
- burst_count saturates at MAX_BURSTS and holds its value in HOLDOFF/IDLE until the next trigger.
- Mid-operation async reset forces IDLE immediately with all outputs low.
- tick when no state uses it has no effect.

Optional Feature:
- Macro ALARM_FLASH_EN.
- Defined: display_blank = 1 in BEEP_ON, otherwise 0. The display flashes in step with the buzzer, with identical timing and latency to buzzer.
- Undefined: display_blank is held 0 and no extra logic is present.

Test Plan:
- Reset: reset=0 mid-BEEP_ON -> buzzer=0, alarm_active=0, expired=0, burst_count=0 immediately. Stays IDLE after release with timer_done=1 held.
- Single burst timing: params 2/1/3/4/2, tick every cycle, timer_en=1, timer_done 0->1.
  - buzzer pattern from the cycle after the edge: 11 0 11 0 11 0000, then repeats.
  - burst_count=1 after the first gap begins.
- Expiry, same params, no ack: after 2 bursts the block enters HOLDOFF.
  - expired=1, burst_count=2, buzzer=0.
  - Holds until timer_done=0, then IDLE; expired stays 1.
- Ack: ack=1 during the second beep -> buzzer=0 the next edge, state HOLDOFF, alarm_active=0.
  - timer_done held 1 for 50 cycles: no retrigger.
  - timer_done low then high -> a new alarm starts.
- Disable and priority:
  - timer_en=0 with ack=1 in BEEP_OFF -> IDLE and expired cleared.
  - timer_done edge with timer_en=0 -> no alarm.
  - ack=1 coincident with the done edge -> no alarm.
- With ALARM_FLASH_EN defined, display_blank equals buzzer every cycle of the single-burst scenario; undefined, it stays 0 throughout.
